fc1_blk_lock: RTL and testbench
===============================

# fc1_blk_lock

Receive-side 64b/66b block-lock engine for the FC1 KR datapath, one instance per channel in the iRX_CLK domain. It consumes the 2-bit sync header of each received 66-bit block, hunts for header alignment by pulsing a bitslip request to the PMA gearbox, and declares or drops block lock. It is the receive counterpart of the encoder's sync-header insertion and sources the decoder's block-sync and bitslip outputs, plus the PCS LOS interval statistic.

## Interface
Parameters:
- SLIP_WAIT, 8: iSH_V beats ignored after each bitslip while the gearbox settles (1..255).
- SH_WIN, 64: headers per evaluation window (power of two, 16..256).
- INVLD_MAX, 16: invalid headers within a locked window that drop lock (1..SH_WIN).

Ports:
- iRX_CLK  in  1  receive clock; the only clock.
- iRX_RST  in  1  reset: synchronous, active-high.
- iSH  in  2  sync header of the current block.
- iSH_V  in  1  iSH is valid this cycle (one beat per 66-bit block).
- iSTATS_LATCH_CLR  in  1  interval latch/clear strike, already synchronized to iRX_CLK.
- oBLOCK_LOCK  out  1  block lock achieved.
- oBITSLIP  out  1  one-cycle slip request to the gearbox.
- oLOCK_LOST  out  1  one-cycle pulse when lock drops.
- oLOS_CNT  out  32  lock-loss events in the previous interval.
- oSLIP_CNT  out  32  bitslips in the previous interval.

## Operation
- Valid header: iSH == 2'b01 or 2'b10. Invalid: 2'b00 or 2'b11.
- Only cycles with iSH_V=1 are counted. sh_cnt is 0..SH_WIN-1; invld_cnt is 0..INVLD_MAX.
- States: HUNT, LOCKED, SLIP, SETTLE. Reset state is HUNT with both counters 0.
- HUNT (oBLOCK_LOCK=0):
  - Invalid header -> SLIP.
  - Valid header with sh_cnt == SH_WIN-1 -> LOCKED, counters cleared.
  - Otherwise sh_cnt increments.
- LOCKED (oBLOCK_LOCK=1): each beat increments sh_cnt; an invalid header also increments invld_cnt.
  - invld_cnt reaching INVLD_MAX on this beat -> SLIP, oLOCK_LOST pulse, lock deasserts. This takes priority over the window end.
  - Otherwise, at sh_cnt == SH_WIN-1, both counters clear and the state stays LOCKED.
- SLIP: one cycle; oBITSLIP=1 -> SETTLE with wait counter = SLIP_WAIT.
- SETTLE: each iSH_V beat decrements the wait counter and the header is ignored. At 0 -> HUNT with counters cleared.
- iRX_RST in any state forces HUNT and clears all counters and all outputs on the next edge, including a mid-slip or mid-settle state.

## Timing
- All outputs are registered. Reset values: oBLOCK_LOCK=0, oBITSLIP=0, oLOCK_LOST=0, oLOS_CNT=0, oSLIP_CNT=0.
- oBITSLIP rises 2 cycles after the decisive beat (state register, then the SLIP output cycle). It is never asserted on consecutive cycles.
- oBLOCK_LOCK rises 1 cycle after the 64th consecutive valid beat.
- oBLOCK_LOCK falls, and oLOCK_LOST pulses, 1 cycle after the INVLD_MAX-th invalid beat.
- Minimum spacing between slips is SLIP_WAIT+1 iSH_V beats plus 2 cycles.
- Idle cycles (iSH_V=0) hold all state.

## Configuration
- FC1_BLK_LOCK_STATS_EN defined:
  - Two saturating 32-bit event counters: oLOCK_LOST events and oBITSLIP events.
  - On iSTATS_LATCH_CLR, each output register captures the live count and the live counter restarts at 0. If an event occurs in the same cycle, the new interval starts at 1.
  - Counters saturate at 32'hFFFF_FFFF.
- Undefined: oLOS_CNT and oSLIP_CNT tied to 0 and no counter logic is built. Lock behaviour is identical either way.

## Structure
- fc1_pkg additions:
  - typedef enum logic [1:0] fc1_blk_lock_st_e {HUNT, LOCKED, SLIP, SETTLE}.
  - localparams FC1_SH_DATA=2'b01 and FC1_SH_CTRL=2'b10.
- Sub-module fc1_stat_lat_cnt (saturating counter with latch/clear, 32-bit), instantiated twice under FC1_BLK_LOCK_STATS_EN.
- fc1_kr instantiates one fc1_blk_lock per channel, on the synchronized RX reset.

## Test plan
- 64 beats of iSH=2'b01 after reset -> oBLOCK_LOCK=1 one cycle after the 64th beat; oBITSLIP never asserted.
- HUNT with iSH=2'b11 on beat 10 -> oBITSLIP pulse 2 cycles later; the next 8 beats are ignored (all 2'b00 still gives no extra slip); lock follows after 64 further valid beats.
- Locked, then 15 invalid headers in a 64-beat window -> lock held. 16 invalid headers in one window -> oLOCK_LOST pulse, oBLOCK_LOCK=0, one oBITSLIP.
- Locked, with the 16th invalid header on the window's last beat -> lock lost (priority check).
- iSH_V toggling at 50% with valid headers -> lock after exactly 64 valid beats. iRX_RST asserted during SETTLE -> HUNT with all outputs 0 next cycle.
- With FC1_BLK_LOCK_STATS_EN: 3 lock losses, then iSTATS_LATCH_CLR -> oLOS_CNT=3 and live count 0. A slip coincident with the clear -> oSLIP_CNT=prior total, next interval starts at 1.

Source files
------------

// File: rtl/fc1_pkg.sv
// Shared FC1 PCS types: block-lock FSM states and 64b/66b sync-header codes.
package fc1_pkg;

  typedef enum logic [1:0] {HUNT, LOCKED, SLIP, SETTLE} fc1_blk_lock_st_e;

  localparam logic [1:0] FC1_SH_DATA = 2'b01;
  localparam logic [1:0] FC1_SH_CTRL = 2'b10;

  function automatic logic fc1_sh_valid(input logic [1:0] sh);
    return (sh == FC1_SH_DATA) || (sh == FC1_SH_CTRL);
  endfunction

endpackage

// File: rtl/fc1_stat_lat_cnt.sv
// Saturating event counter whose value is captured into an output register
// and restarted on each interval latch/clear strike.
module fc1_stat_lat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         evt,
  input  logic         latch_clr,
  output logic [W-1:0] latched
);

  logic [W-1:0] live;

  // An event coinciding with the strike belongs to the new interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      live    <= '0;
      latched <= '0;
    end else if (latch_clr) begin
      latched <= live;
      live    <= evt ? W'(1) : '0;
    end else if (evt && (live != '1)) begin
      live <= live + W'(1);
    end
  end

endmodule

// File: rtl/fc1_blk_lock.sv
// 64b/66b receive block-lock engine: hunts for sync-header alignment with
// bitslip requests. Optional interval statistics: FC1_BLK_LOCK_STATS_EN.
//
// state  | meaning
// HUNT   | counting consecutive valid headers, lock not held
// LOCKED | lock held, counting invalid headers per window
// SLIP   | one-cycle bitslip request to the gearbox
// SETTLE | ignoring SLIP_WAIT beats while the gearbox settles
module fc1_blk_lock
  import fc1_pkg::*;
#(
  parameter int SLIP_WAIT = 8,
  parameter int SH_WIN    = 64,
  parameter int INVLD_MAX = 16
) (
  input  logic        iRX_CLK,
  input  logic        iRX_RST,
  input  logic [1:0]  iSH,
  input  logic        iSH_V,
  input  logic        iSTATS_LATCH_CLR,
  output logic        oBLOCK_LOCK,
  output logic        oBITSLIP,
  output logic        oLOCK_LOST,
  output logic [31:0] oLOS_CNT,
  output logic [31:0] oSLIP_CNT
);

  localparam int SH_W = $clog2(SH_WIN);
  localparam int IV_W = $clog2(INVLD_MAX + 1);
  localparam logic [SH_W-1:0] SH_LAST   = SH_W'(SH_WIN - 1);
  localparam logic [IV_W-1:0] IV_LAST   = IV_W'(INVLD_MAX - 1);
  localparam logic [7:0]      WAIT_INIT = 8'(SLIP_WAIT);

  fc1_blk_lock_st_e st_q, st_d;
  logic [SH_W-1:0]  sh_cnt_q, sh_cnt_d;
  logic [IV_W-1:0]  invld_cnt_q, invld_cnt_d;
  logic [7:0]       wait_q, wait_d;
  logic             lock_d, slip_d, lost_d;
  logic             sh_ok;

  assign sh_ok = fc1_sh_valid(iSH);

  always_comb begin
    st_d        = st_q;
    sh_cnt_d    = sh_cnt_q;
    invld_cnt_d = invld_cnt_q;
    wait_d      = wait_q;
    slip_d      = 1'b0;
    lost_d      = 1'b0;
    case (st_q)
      HUNT: begin
        if (iSH_V) begin
          if (!sh_ok) begin
            st_d     = SLIP;
            sh_cnt_d = '0;
          end else if (sh_cnt_q == SH_LAST) begin
            st_d        = LOCKED;
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_cnt_q + SH_W'(1);
          end
        end
      end
      LOCKED: begin
        // Losing lock wins over the window rollover on the same beat.
        if (iSH_V) begin
          if (!sh_ok && (invld_cnt_q == IV_LAST)) begin
            st_d        = SLIP;
            lost_d      = 1'b1;
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
          end else if (sh_cnt_q == SH_LAST) begin
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_cnt_q + SH_W'(1);
            if (!sh_ok) invld_cnt_d = invld_cnt_q + IV_W'(1);
          end
        end
      end
      SLIP: begin
        slip_d = 1'b1;
        st_d   = SETTLE;
        wait_d = WAIT_INIT;
      end
      SETTLE: begin
        if (iSH_V) begin
          if (wait_q == 8'd1) begin
            st_d        = HUNT;
            wait_d      = '0;
            sh_cnt_d    = '0;
            invld_cnt_d = '0;
          end else begin
            wait_d = wait_q - 8'd1;
          end
        end
      end
      default: st_d = HUNT;
    endcase
    lock_d = (st_d == LOCKED);
  end

  always_ff @(posedge iRX_CLK) begin
    if (iRX_RST) begin
      st_q        <= HUNT;
      sh_cnt_q    <= '0;
      invld_cnt_q <= '0;
      wait_q      <= '0;
      oBLOCK_LOCK <= 1'b0;
      oBITSLIP    <= 1'b0;
      oLOCK_LOST  <= 1'b0;
    end else begin
      st_q        <= st_d;
      sh_cnt_q    <= sh_cnt_d;
      invld_cnt_q <= invld_cnt_d;
      wait_q      <= wait_d;
      oBLOCK_LOCK <= lock_d;
      oBITSLIP    <= slip_d;
      oLOCK_LOST  <= lost_d;
    end
  end

`ifdef FC1_BLK_LOCK_STATS_EN
  fc1_stat_lat_cnt #(.W(32)) u_los_cnt (
    .clk       (iRX_CLK),
    .rst       (iRX_RST),
    .evt       (oLOCK_LOST),
    .latch_clr (iSTATS_LATCH_CLR),
    .latched   (oLOS_CNT)
  );

  fc1_stat_lat_cnt #(.W(32)) u_slip_cnt (
    .clk       (iRX_CLK),
    .rst       (iRX_RST),
    .evt       (oBITSLIP),
    .latch_clr (iSTATS_LATCH_CLR),
    .latched   (oSLIP_CNT)
  );
`else
  logic unused_stats_clr;
  assign unused_stats_clr = iSTATS_LATCH_CLR;
  assign oLOS_CNT  = '0;
  assign oSLIP_CNT = '0;
`endif

endmodule

// File: tb/tb_fc1_blk_lock.sv
// Scoreboard bench for fc1_blk_lock: a header-level reference model predicts
// every post-edge output; a monitor pops and compares one cycle at a time.
module tb_fc1_blk_lock;

  localparam int SLIP_WAIT = 8;
  localparam int SH_WIN    = 64;
  localparam int INVLD_MAX = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sh  = 2'b00;
  logic        v   = 1'b0;
  logic        clr = 1'b0;
  logic        blk_lock, bitslip, lock_lost;
  logic [31:0] los_cnt, slip_cnt;

  always #5 clk = ~clk;

  fc1_blk_lock #(.SLIP_WAIT(SLIP_WAIT), .SH_WIN(SH_WIN), .INVLD_MAX(INVLD_MAX)) dut (
    .iRX_CLK          (clk),
    .iRX_RST          (rst),
    .iSH              (sh),
    .iSH_V            (v),
    .iSTATS_LATCH_CLR (clr),
    .oBLOCK_LOCK      (blk_lock),
    .oBITSLIP         (bitslip),
    .oLOCK_LOST       (lock_lost),
    .oLOS_CNT         (los_cnt),
    .oSLIP_CNT        (slip_cnt)
  );

  typedef struct packed {
    logic        lock;
    logic        slip;
    logic        lost;
    logic [31:0] los;
    logic [31:0] slips;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: header run lengths, window tallies and pending actions.
  bit          m_locked, m_slip_due, m_slip, m_lost;
  int          m_run, m_win, m_bad, m_settle;
  logic [31:0] m_los_live, m_los_out, m_slip_live, m_slip_out;

  function automatic void stat_upd(inout logic [31:0] live, inout logic [31:0] out,
                                   input bit ev, input bit c);
    if (c) begin
      out  = live;
      live = ev ? 32'd1 : 32'd0;
    end else if (ev && live != 32'hFFFF_FFFF) begin
      live = live + 32'd1;
    end
  endfunction

  function automatic void model_step(bit r, logic [1:0] h, bit val, bit c);
    bit good = (h == 2'b01) || (h == 2'b10);
    bit ev_lost = m_lost;
    bit ev_slip = m_slip;
    if (r) begin
      m_locked = 0; m_slip_due = 0; m_slip = 0; m_lost = 0;
      m_run = 0; m_win = 0; m_bad = 0; m_settle = 0;
      m_los_live = 0; m_los_out = 0; m_slip_live = 0; m_slip_out = 0;
      return;
    end
    stat_upd(m_los_live, m_los_out, ev_lost, c);
    stat_upd(m_slip_live, m_slip_out, ev_slip, c);
    m_slip = 0;
    m_lost = 0;
    if (m_slip_due) begin
      m_slip     = 1;
      m_slip_due = 0;
      m_settle   = SLIP_WAIT;
    end else if (val) begin
      if (m_settle > 0) begin
        m_settle--;
        m_run = 0;
      end else if (!m_locked) begin
        if (good) begin
          m_run++;
          if (m_run == SH_WIN) begin
            m_locked = 1; m_run = 0; m_win = 0; m_bad = 0;
          end
        end else begin
          m_slip_due = 1;
          m_run      = 0;
        end
      end else begin
        m_win++;
        if (!good) m_bad++;
        if (m_bad == INVLD_MAX) begin
          m_locked = 0; m_lost = 1; m_slip_due = 1; m_run = 0;
        end else if (m_win == SH_WIN) begin
          m_win = 0; m_bad = 0;
        end
      end
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.lock = m_locked;
    o.slip = m_slip;
    o.lost = m_lost;
`ifdef FC1_BLK_LOCK_STATS_EN
    o.los   = m_los_out;
    o.slips = m_slip_out;
`else
    o.los   = 32'd0;
    o.slips = 32'd0;
`endif
    return o;
  endfunction

  task automatic step(bit r, logic [1:0] h, bit val, bit c);
    @(negedge clk);
    rst = r; sh = h; v = val; clr = c;
    model_step(r, h, val, c);
    exp_q.push_back(model_obs());
  endtask

  function automatic logic [1:0] rnd_good();
    return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] rnd_bad();
    return ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
  endfunction

  task automatic good_beats(int n);
    for (int i = 0; i < n; i++) step(0, rnd_good(), 1, 0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) step(1, 2'b00, 0, 0);
  endtask

  // One aligned locked window with nbad invalid headers, clustered at the end or scattered.
  task automatic window(int nbad, bit at_end);
    bit f[SH_WIN];
    int cnt = 0;
    for (int i = 0; i < SH_WIN; i++) f[i] = 0;
    if (at_end) begin
      for (int i = SH_WIN - nbad; i < SH_WIN; i++) f[i] = 1;
    end else begin
      while (cnt < nbad) begin
        int k = $urandom_range(0, SH_WIN - 1);
        if (!f[k]) begin f[k] = 1; cnt++; end
      end
    end
    for (int i = 0; i < SH_WIN; i++) step(0, f[i] ? rnd_bad() : rnd_good(), 1, 0);
  endtask

  initial begin : monitor
    obs_t e, g;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{lock: blk_lock, slip: bitslip, lost: lock_lost, los: los_cnt, slips: slip_cnt};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL outputs cyc=%0d got lock=%b slip=%b lost=%b los=%0d slips=%0d expected lock=%b slip=%b lost=%b los=%0d slips=%0d",
                   cyc, g.lock, g.slip, g.lost, g.los, g.slips, e.lock, e.slip, e.lost, e.los, e.slips);
        end
      end
    end
  end

  initial begin : driver
    int p_bad;
    do_reset();
    step(1, 2'b00, 0, 0);

    // Straight lock from reset, then idle beats with garbage headers.
    good_beats(SH_WIN);
    for (int i = 0; i < 4; i++) step(0, rnd_bad(), 0, 0);

    // Invalid on beat 10 of hunt; settle beats all 2'b00; relock.
    do_reset();
    good_beats(9);
    step(0, 2'b11, 1, 0);
    for (int i = 0; i < SLIP_WAIT + 1; i++) step(0, 2'b00, 1, 0);
    good_beats(SH_WIN + 4);

    // INVLD_MAX-1 invalids hold lock; INVLD_MAX in one window drops it.
    do_reset();
    good_beats(SH_WIN);
    window(INVLD_MAX - 1, 0);
    window(INVLD_MAX, 0);
    good_beats(SH_WIN + SLIP_WAIT + 4);

    // Last invalid lands on the window's final beat.
    do_reset();
    good_beats(SH_WIN);
    window(INVLD_MAX, 1);
    good_beats(SLIP_WAIT + 4);

    // Valid flag toggling every cycle.
    do_reset();
    for (int i = 0; i < 2 * SH_WIN + 4; i++) step(0, rnd_good(), (i % 2) == 0, 0);

    // Reset while settling.
    do_reset();
    good_beats(3);
    step(0, 2'b00, 1, 0);
    for (int i = 0; i < 4; i++) step(0, rnd_good(), 1, 0);
    step(1, 2'b01, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 2'b01, 0, 0);

    // Three lock losses, interval strike, then a strike coincident with a slip.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      good_beats(SH_WIN);
      for (int i = 0; i < INVLD_MAX; i++) step(0, rnd_bad(), 1, 0);
      good_beats(SLIP_WAIT + 1);
    end
    step(0, 2'b01, 0, 1);
    step(0, 2'b01, 0, 0);
    step(0, 2'b11, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 2'b01, 0, m_slip);
    for (int i = 0; i < 3; i++) step(0, 2'b01, 0, 0);
    step(0, 2'b01, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 2'b01, 0, 0);

    // Randomized traffic with varying invalid density, strikes and resets.
    for (int seg = 0; seg < 12; seg++) begin
      p_bad = (seg % 3 == 0) ? 200 : ((seg % 3 == 1) ? 12 : 3);
      for (int i = 0; i < 350; i++) begin
        step(($urandom_range(0, 999) == 0),
             ($urandom_range(0, p_bad - 1) == 0) ? rnd_bad() : rnd_good(),
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 79) == 0));
      end
    end

    step(0, 2'b01, 0, 1);
    step(0, 2'b01, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
